// File: rtl/hdc_csr_v2_if.sv
// Host-side CSR request/response handshake bundle for hdc_csr_v2.
// Latency: none (wires only).
// Backpressure: req side is valid/ready, rsp side is valid/ready; the slave owns both readies' meaning.
// Signals keep the block-level port names (suffix as seen from the CSR block):
//   csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i : host -> CSR
//   csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o                          : CSR -> host
interface hdc_csr_v2_if #(
    parameter int CSR_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 32
);
    logic [CSR_ADDR_WIDTH-1:0] csr_addr_i;
    logic [CSR_WIDTH-1:0]      csr_wr_data_i;
    logic                      csr_wr_en_i;
    logic                      csr_req_valid_i;
    logic                      csr_req_ready_o;
    logic [CSR_WIDTH-1:0]      csr_rd_data_o;
    logic                      csr_rsp_valid_o;
    logic                      csr_rsp_ready_i;

    // Host side.
    modport master (
        output csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
        input  csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
    );

    // CSR block side.
    modport slave (
        input  csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
        output csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
    );
endinterface

// File: rtl/hdc_csr_v2.sv
// CSR file for the SBD-HDC accelerator: config decode, input-sample FIFO, sticky overflow, start/soft-reset pulses.
// Latency: request accepted in cycle N -> response, register update, pulses and FIFO push visible in N+1.
// Backpressure: one response outstanding; csr_req_ready_o = !csr_rsp_valid_o || csr_rsp_ready_i.
//
// Ports: clk_i / rst_i (synchronous, active high); csr (hdc_csr_v2_if.slave) host request/response;
//   csr_start_o, soft_reset_o one-cycle pulses; in_valid/in_value/shift_amount_in/input_done is the
//   FIFO head, popped by in_ready; running/output_valid/out are core status; the remaining outputs are
//   binding/bundling fields and associative-memory bounds.
// Optional feature: define HDC_CSR_PERF_CNT_EN to add the saturating running-cycle counter at address 9.

// Small synchronous FIFO with flush. A push while full is taken only if a pop frees a slot in the
// same cycle; otherwise it is dropped and drop_o flags it.
module hdc_csr_v2_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o,
    output logic             drop_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok, push_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && full_o && !pop_ok;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module hdc_csr_v2 #(
    parameter int CSR_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 32,
    parameter int IN_FIFO_DEPTH  = 4,
    parameter int CNT_W          = $clog2(IN_FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hdc_csr_v2_if.slave          csr,
    output logic                 csr_start_o,
    output logic                 soft_reset_o,
    // input FIFO head towards the core
    output logic                 in_valid,
    output logic [5:0]           in_value,
    output logic [5:0]           shift_amount_in,
    output logic                 input_done,
    input  logic                 in_ready,
    // core status
    input  logic                 running,
    input  logic                 output_valid,
    input  logic [4:0]           out,
    // binding fields
    output logic                 sliding_window_mode,
    output logic                 signature_encoding_mode,
    output logic                 shift_binding_mode,
    // bundling fields
    output logic                 acc1_mode,
    output logic                 cdt_mode,
    output logic                 acc2_mode,
    output logic [5:0]           window1_size,
    output logic [3:0]           cdt_k_factor,
    output logic [2:0]           thr1_val,
    output logic [6:0]           thr2_val,
    output logic                 or_mode,
    output logic                 am_write_encoded,
    // associative-memory bounds
    output logic [CSR_WIDTH-1:0] am_addr_base,
    output logic [CSR_WIDTH-1:0] am_addr_max
);
    typedef logic [CSR_ADDR_WIDTH-1:0] addr_t;

    localparam addr_t A_START  = addr_t'(0);
    localparam addr_t A_INPUT  = addr_t'(1);
    localparam addr_t A_STATUS = addr_t'(2);
    localparam addr_t A_PBIND  = addr_t'(3);
    localparam addr_t A_PBUND  = addr_t'(4);
    localparam addr_t A_AMBASE = addr_t'(5);
    localparam addr_t A_AMMAX  = addr_t'(6);
    localparam addr_t A_RESET  = addr_t'(7);
    localparam addr_t A_CLEAR  = addr_t'(8);
`ifdef HDC_CSR_PERF_CNT_EN
    localparam addr_t A_PERF   = addr_t'(9);
`endif

    // FIFO entry is the INPUT write payload without its ignored bit 0: {done, shift[5:0], value[5:0]}.
    localparam int ENT_W = 13;

    logic                 rsp_valid_q;
    logic [CSR_WIDTH-1:0] rd_data_q;
    logic                 start_q, soft_reset_q, clear_q, overflow_q;
    logic [CSR_WIDTH-1:0] p_binding_q, p_bundling_q, am_base_q, am_max_q;

    logic                 req_rdy, req_acc, wr_acc;
    logic                 push, pop;
    logic [ENT_W-1:0]     head;
    logic                 fifo_empty, fifo_full, fifo_drop;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [CSR_WIDTH-1:0] rd_mux;

    // ---------------- handshake ----------------
    assign req_rdy = !rsp_valid_q || csr.csr_rsp_ready_i;
    assign req_acc = csr.csr_req_valid_i && req_rdy;
    assign wr_acc  = req_acc && csr.csr_wr_en_i;

    assign csr.csr_req_ready_o = req_rdy;
    assign csr.csr_rsp_valid_o = rsp_valid_q;
    assign csr.csr_rd_data_o   = rd_data_q;

    // ---------------- input FIFO ----------------
    assign push = wr_acc && (csr.csr_addr_i == A_INPUT);
    assign pop  = in_valid && in_ready;

    // Flush runs while soft_reset_o is high, so a push accepted in that same cycle is lost.
    hdc_csr_v2_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (IN_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_in_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (soft_reset_q),
        .push_i     (push),
        .push_dat_i (csr.csr_wr_data_i[13:1]),
        .pop_i      (pop),
        .head_dat_o (head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_cnt),
        .drop_o     (fifo_drop)
    );

    assign in_valid        = !fifo_empty;
    assign in_value        = head[5:0];
    assign shift_amount_in = head[11:6];
    assign input_done      = head[12];

`ifdef HDC_CSR_PERF_CNT_EN
    // ---------------- running-cycle counter ----------------
    logic [CSR_WIDTH-1:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (soft_reset_q || start_q) begin
            perf_q <= '0;
        end else if (running && (perf_q != '1)) begin
            perf_q <= perf_q + CSR_WIDTH'(1);
        end
    end
`endif

    // ---------------- read mux (samples state before this cycle's push/pop) ----------------
    always_comb begin
        rd_mux = '0;
        case (csr.csr_addr_i)
            A_INPUT: begin
                if (!fifo_empty) begin
                    rd_mux[13:1] = head;
                end
            end
            A_STATUS: begin
                rd_mux[0]            = running;
                rd_mux[1]            = in_ready;
                rd_mux[2]            = output_valid;
                rd_mux[7:3]          = out;
                rd_mux[8]            = fifo_empty;
                rd_mux[9]            = fifo_full;
                rd_mux[10]           = overflow_q;
                rd_mux[16 +: CNT_W]  = fifo_cnt;
            end
            A_PBIND:  rd_mux = p_binding_q;
            A_PBUND:  rd_mux = p_bundling_q;
            A_AMBASE: rd_mux = am_base_q;
            A_AMMAX:  rd_mux = am_max_q;
`ifdef HDC_CSR_PERF_CNT_EN
            A_PERF:   rd_mux = perf_q;
`endif
            default:  rd_mux = '0;
        endcase
    end

    // ---------------- response, registers, pulses ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q  <= 1'b0;
            rd_data_q    <= '0;
            start_q      <= 1'b0;
            soft_reset_q <= 1'b0;
            clear_q      <= 1'b0;
            p_binding_q  <= '0;
            p_bundling_q <= '0;
            am_base_q    <= '0;
            am_max_q     <= '0;
        end else begin
            if (req_acc) begin
                rsp_valid_q <= 1'b1;
                rd_data_q   <= csr.csr_wr_en_i ? '0 : rd_mux;
            end else if (csr.csr_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end

            start_q      <= wr_acc && (csr.csr_addr_i == A_START) && csr.csr_wr_data_i[0];
            soft_reset_q <= wr_acc && (csr.csr_addr_i == A_RESET) && csr.csr_wr_data_i[0];
            clear_q      <= wr_acc && (csr.csr_addr_i == A_CLEAR) && csr.csr_wr_data_i[0];

            if (wr_acc) begin
                case (csr.csr_addr_i)
                    A_PBIND:  p_binding_q  <= csr.csr_wr_data_i;
                    A_PBUND:  p_bundling_q <= csr.csr_wr_data_i;
                    A_AMBASE: am_base_q    <= csr.csr_wr_data_i;
                    A_AMMAX:  am_max_q     <= csr.csr_wr_data_i;
                    default:  ;
                endcase
            end
        end
    end

    // Overflow: soft reset beats a drop (entry is flushed anyway); a drop beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (soft_reset_q) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end else if (clear_q) begin
            overflow_q <= 1'b0;
        end
    end

    // ---------------- field decode ----------------
    assign csr_start_o             = start_q;
    assign soft_reset_o            = soft_reset_q;

    assign sliding_window_mode     = p_binding_q[0];
    assign signature_encoding_mode = p_binding_q[1];
    assign shift_binding_mode      = p_binding_q[2];

    assign acc1_mode               = p_bundling_q[0];
    assign cdt_mode                = p_bundling_q[1];
    assign acc2_mode               = p_bundling_q[2];
    assign window1_size            = p_bundling_q[8:3];
    assign cdt_k_factor            = p_bundling_q[12:9];
    assign thr1_val                = p_bundling_q[15:13];
    assign thr2_val                = p_bundling_q[22:16];
    assign or_mode                 = p_bundling_q[23];
    assign am_write_encoded        = p_bundling_q[24];

    assign am_addr_base            = am_base_q;
    assign am_addr_max             = am_max_q;
endmodule

// File: tb/tb_hdc_csr_v2.sv
// Self-checking bench for hdc_csr_v2: register table plus hand sequences for FIFO, pulses and handshake.
// Latency: n/a (testbench).
// Backpressure: exercised directly by holding csr_rsp_ready_i low.
module tb_hdc_csr_v2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdc_csr_v2_if #(.CSR_WIDTH(32), .CSR_ADDR_WIDTH(32)) csr_if ();

    logic        start_o, sreset_o, in_valid, input_done;
    logic [5:0]  in_value, shift_amount_in, window1_size;
    logic        in_ready = 1'b0, running = 1'b0, output_valid = 1'b0;
    logic [4:0]  out = 5'd0;
    logic        sliding, sig_mode, shift_mode, acc1, cdt, acc2, or_mode, am_write;
    logic [3:0]  k_factor;
    logic [2:0]  thr1;
    logic [6:0]  thr2;
    logic [31:0] am_base, am_max;

    hdc_csr_v2 dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .csr                     (csr_if),
        .csr_start_o             (start_o),
        .soft_reset_o            (sreset_o),
        .in_valid                (in_valid),
        .in_value                (in_value),
        .shift_amount_in         (shift_amount_in),
        .input_done              (input_done),
        .in_ready                (in_ready),
        .running                 (running),
        .output_valid            (output_valid),
        .out                     (out),
        .sliding_window_mode     (sliding),
        .signature_encoding_mode (sig_mode),
        .shift_binding_mode      (shift_mode),
        .acc1_mode               (acc1),
        .cdt_mode                (cdt),
        .acc2_mode               (acc2),
        .window1_size            (window1_size),
        .cdt_k_factor            (k_factor),
        .thr1_val                (thr1),
        .thr2_val                (thr2),
        .or_mode                 (or_mode),
        .am_write_encoded        (am_write),
        .am_addr_base            (am_base),
        .am_addr_max             (am_max)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        run;
        logic        rdy;
        logic        ov;
        logic [4:0]  outv;
        logic [31:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t        vecs[15];
    logic [12:0] ent[5];   // {done, shift, value}
    logic [31:0] rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request with the response taken immediately; returns at the negedge of cycle N+1.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata);
        @(negedge clk);
        csr_if.csr_req_valid_i = 1'b1;
        csr_if.csr_wr_en_i     = wr;
        csr_if.csr_addr_i      = addr;
        csr_if.csr_wr_data_i   = data;
        csr_if.csr_rsp_ready_i = 1'b1;
        #1;
        check("req_ready", 32'(csr_if.csr_req_ready_o), 32'h1);
        @(posedge clk);
        #1 csr_if.csr_req_valid_i = 1'b0;
        @(negedge clk);
        check("rsp_valid", 32'(csr_if.csr_rsp_valid_o), 32'h1);
        rdata = csr_if.csr_rd_data_o;
    endtask

    task automatic push(input logic [12:0] e);
        logic [31:0] dummy;
        txn(1'b1, 32'd1, {18'b0, e, 1'b0}, dummy);
    endtask

    // Caller sits at a negedge; pops n entries expecting ent[first..first+n-1], then checks empty.
    task automatic drain(input int first, input int n);
        in_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("drain_vld%0d", k), 32'(in_valid), 32'h1);
            check($sformatf("drain_head%0d", k),
                  32'({input_done, shift_amount_in, in_value}), 32'(ent[first + k]));
            @(negedge clk);
        end
        check("drain_empty", 32'(in_valid), 32'h0);
        in_ready = 1'b0;
    endtask

    initial begin
        csr_if.csr_req_valid_i = 1'b0;
        csr_if.csr_wr_en_i     = 1'b0;
        csr_if.csr_addr_i      = '0;
        csr_if.csr_wr_data_i   = '0;
        csr_if.csr_rsp_ready_i = 1'b1;

        ent[0] = {1'b0, 6'd2,  6'd1};
        ent[1] = {1'b0, 6'd20, 6'd10};
        ent[2] = {1'b0, 6'd40, 6'd33};
        ent[3] = {1'b1, 6'd63, 6'd63};
        ent[4] = {1'b1, 6'd7,  6'd5};

        //            wr    addr           wdata          run   rdy   ov    out     expected
        vecs[0]  = '{1'b0, 32'h4,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h01A5_5E07};
        vecs[1]  = '{1'b1, 32'h5,        32'h1000,      1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[2]  = '{1'b1, 32'h6,        32'h1FFF,      1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[3]  = '{1'b0, 32'h5,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h1000};
        vecs[4]  = '{1'b0, 32'h6,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h1FFF};
        vecs[5]  = '{1'b0, 32'h3,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h5};
        vecs[6]  = '{1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[7]  = '{1'b0, 32'h7,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[8]  = '{1'b0, 32'h8,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[9]  = '{1'b1, 32'h2,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[10] = '{1'b0, 32'h2,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h100};
        vecs[11] = '{1'b0, 32'h2,        32'h0,         1'b1, 1'b1, 1'b1, 5'h15, 32'h1AF};
        vecs[12] = '{1'b1, 32'h13,       32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0};
        vecs[13] = '{1'b0, 32'h3,        32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h5};
        vecs[14] = '{1'b0, 32'h1_0004,   32'h0,         1'b0, 1'b0, 1'b0, 5'h00, 32'h0};

        // ---- reset ----
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(csr_if.csr_req_ready_o), 32'h1);
        check("rst_rsp_valid", 32'(csr_if.csr_rsp_valid_o), 32'h0);
        check("rst_rd_data", csr_if.csr_rd_data_o, 32'h0);
        check("rst_core_if", 32'({start_o, sreset_o, in_valid, in_value, shift_amount_in, input_done}), 32'h0);
        check("rst_cfg", 32'({sliding, sig_mode, shift_mode, acc1, cdt, acc2, window1_size,
                              k_factor, thr1, thr2, or_mode, am_write}), 32'h0);
        check("rst_am_base", am_base, 32'h0);
        check("rst_am_max", am_max, 32'h0);
        txn(1'b0, 32'd2, 32'h0, rd);
        check("rst_status", rd, 32'h100);

        // ---- config writes, fields visible at N+1 ----
        txn(1'b1, 32'd4, 32'h01A5_5E07, rd);
        check("bund_wr_rdata", rd, 32'h0);
        check("bund_window1", 32'(window1_size), 32'h0);
        check("bund_k", 32'(k_factor), 32'hF);
        check("bund_thr1", 32'(thr1), 32'h2);
        check("bund_thr2", 32'(thr2), 32'h25);
        check("bund_am_write", 32'(am_write), 32'h1);
        check("bund_modes", 32'({acc1, cdt, acc2, or_mode}), 32'hF);
        txn(1'b1, 32'd3, 32'h5, rd);
        check("bind_modes", 32'({sliding, sig_mode, shift_mode}), 32'h5);

        // ---- register table ----
        for (int i = 0; i < 15; i++) begin
            running      = vecs[i].run;
            in_ready     = vecs[i].rdy;
            output_valid = vecs[i].ov;
            out          = vecs[i].outv;
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end
        running = 1'b0; in_ready = 1'b0; output_valid = 1'b0; out = 5'd0;
        check("am_base_port", am_base, 32'h1000);
        check("am_max_port", am_max, 32'h1FFF);

        // ---- FIFO fill past full, then drain in order ----
        for (int k = 0; k < 5; k++) begin
            push(ent[k]);
            if (k == 0) begin
                check("push_vld_n1", 32'(in_valid), 32'h1);
                check("push_head_n1", 32'({input_done, shift_amount_in, in_value}), 32'(ent[0]));
            end
        end
        txn(1'b0, 32'd2, 32'h0, rd);
        check("fill_status", rd, 32'h0004_0600);
        txn(1'b0, 32'd1, 32'h0, rd);
        check("fill_input_rd", rd, {18'b0, ent[0], 1'b0});
        drain(0, 4);
        txn(1'b1, 32'd8, 32'h1, rd);
        txn(1'b0, 32'd2, 32'h0, rd);
        check("clear_status", rd, 32'h100);

        // ---- full FIFO: push and pop in the same cycle ----
        for (int k = 0; k < 4; k++) push(ent[k]);
        @(negedge clk);
        csr_if.csr_req_valid_i = 1'b1;
        csr_if.csr_wr_en_i     = 1'b1;
        csr_if.csr_addr_i      = 32'd1;
        csr_if.csr_wr_data_i   = {18'b0, ent[4], 1'b0};
        in_ready               = 1'b1;
        @(posedge clk);
        #1 csr_if.csr_req_valid_i = 1'b0;
        in_ready = 1'b0;
        txn(1'b0, 32'd2, 32'h0, rd);
        check("pushpop_status", rd, 32'h0004_0200);
        drain(1, 4);

        // ---- CLEAR with a same-cycle overflow: overflow wins ----
        for (int k = 0; k < 4; k++) push(ent[k]);
        @(negedge clk);
        csr_if.csr_req_valid_i = 1'b1;
        csr_if.csr_wr_en_i     = 1'b1;
        csr_if.csr_addr_i      = 32'd8;
        csr_if.csr_wr_data_i   = 32'h1;
        @(posedge clk);
        #1;
        csr_if.csr_addr_i      = 32'd1;
        csr_if.csr_wr_data_i   = {18'b0, ent[4], 1'b0};
        @(posedge clk);
        #1 csr_if.csr_req_valid_i = 1'b0;
        txn(1'b0, 32'd2, 32'h0, rd);
        check("clr_vs_ovf_status", rd, 32'h0004_0600);
        txn(1'b1, 32'd7, 32'h1, rd);
        check("sreset_pulse_hi", 32'(sreset_o), 32'h1);
        @(negedge clk);
        check("sreset_pulse_lo", 32'(sreset_o), 32'h0);
        txn(1'b0, 32'd2, 32'h0, rd);
        check("sreset_status", rd, 32'h100);

        // ---- START pulse, then soft reset with 3 queued and a same-cycle push ----
        for (int k = 0; k < 3; k++) push(ent[k]);
        txn(1'b1, 32'd0, 32'h1, rd);
        check("start_pulse_hi", 32'(start_o), 32'h1);
        @(negedge clk);
        check("start_pulse_lo", 32'(start_o), 32'h0);
        csr_if.csr_req_valid_i = 1'b1;
        csr_if.csr_wr_en_i     = 1'b1;
        csr_if.csr_addr_i      = 32'd7;
        csr_if.csr_wr_data_i   = 32'h1;
        @(posedge clk);
        #1;
        csr_if.csr_addr_i      = 32'd1;
        csr_if.csr_wr_data_i   = {18'b0, ent[3], 1'b0};
        @(negedge clk);
        check("sreset2_hi", 32'(sreset_o), 32'h1);
        @(posedge clk);
        #1 csr_if.csr_req_valid_i = 1'b0;
        @(negedge clk);
        check("sreset2_lo", 32'(sreset_o), 32'h0);
        check("sreset2_empty", 32'(in_valid), 32'h0);
        txn(1'b0, 32'd2, 32'h0, rd);
        check("sreset2_status", rd, 32'h100);
        txn(1'b0, 32'd1, 32'h0, rd);
        check("sreset2_input_rd", rd, 32'h0);
        txn(1'b0, 32'd3, 32'h0, rd);
        check("sreset2_pbind", rd, 32'h5);

        // ---- response backpressure, then back-to-back release ----
        @(negedge clk);
        csr_if.csr_req_valid_i = 1'b1;
        csr_if.csr_wr_en_i     = 1'b0;
        csr_if.csr_addr_i      = 32'd4;
        csr_if.csr_rsp_ready_i = 1'b0;
        @(posedge clk);
        #1 csr_if.csr_addr_i = 32'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_rsp_valid%0d", c), 32'(csr_if.csr_rsp_valid_o), 32'h1);
            check($sformatf("bp_req_ready%0d", c), 32'(csr_if.csr_req_ready_o), 32'h0);
            check($sformatf("bp_rd_data%0d", c), csr_if.csr_rd_data_o, 32'h01A5_5E07);
        end
        csr_if.csr_rsp_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(csr_if.csr_req_ready_o), 32'h1);
        @(posedge clk);
        #1 csr_if.csr_req_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_rsp_valid", 32'(csr_if.csr_rsp_valid_o), 32'h1);
        check("b2b_rd_data", csr_if.csr_rd_data_o, 32'h5);
        @(negedge clk);
        check("b2b_rsp_done", 32'(csr_if.csr_rsp_valid_o), 32'h0);

        // ---- performance counter ----
`ifdef HDC_CSR_PERF_CNT_EN
        txn(1'b1, 32'd0, 32'h1, rd);
        @(negedge clk);
        running = 1'b1;
        repeat (10) @(negedge clk);
        running = 1'b0;
        txn(1'b0, 32'd9, 32'h0, rd);
        check("perf_count", rd, 32'd10);
`else
        running = 1'b1;
        txn(1'b0, 32'd9, 32'h0, rd);
        running = 1'b0;
        check("perf_unmapped", rd, 32'h0);
`endif

        // ---- reset discards a pending response ----
        @(negedge clk);
        csr_if.csr_req_valid_i = 1'b1;
        csr_if.csr_wr_en_i     = 1'b0;
        csr_if.csr_addr_i      = 32'd4;
        csr_if.csr_rsp_ready_i = 1'b0;
        @(posedge clk);
        #1;
        csr_if.csr_req_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_rsp_valid", 32'(csr_if.csr_rsp_valid_o), 32'h0);
        check("rst2_req_ready", 32'(csr_if.csr_req_ready_o), 32'h1);
        check("rst2_rd_data", csr_if.csr_rd_data_o, 32'h0);
        check("rst2_thr2", 32'(thr2), 32'h0);
        check("rst2_am_base", am_base, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
